// File: rtl/obstacle_spawner_pkg.sv
// Shared types and constants for the obstacle spawner: obstacle kinds, FSM
// states, the gap counter width and the gap computation used at decision time.
package obstacle_spawner_pkg;

  localparam int GAP_W = 4;

  typedef enum logic [1:0] {
    OBS_LOW  = 2'd0,
    OBS_HIGH = 2'd1,
    OBS_WIDE = 2'd2,
    OBS_NONE = 2'd3
  } obs_type_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_GAP = 2'd1,
    ST_DECIDE   = 2'd2,
    ST_HOLD     = 2'd3
  } state_e;

  // Gap to the next decision: the base gap plus a 0..3 random stretch.
  function automatic logic [GAP_W-1:0] calc_gap(input logic [GAP_W-1:0] min_gap,
                                                 input logic [1:0]       step);
    return min_gap + {2'b00, step};
  endfunction

endpackage

// File: rtl/obstacle_spawner_if.sv
// Valid/ready obstacle descriptor channel between the spawner and its consumer.
interface obstacle_spawner_if;
  import obstacle_spawner_pkg::*;

  logic             obs_valid_out;
  logic [1:0]       obs_type_out;
  logic [GAP_W-1:0] obs_gap_out;
  logic             obs_ready_in;

  modport master (
    output obs_valid_out,
    output obs_type_out,
    output obs_gap_out,
    input  obs_ready_in
  );

  modport slave (
    input  obs_valid_out,
    input  obs_type_out,
    input  obs_gap_out,
    output obs_ready_in
  );

endinterface

// File: rtl/obstacle_spawner.sv
// Frame-paced obstacle generator: waits a gap of frame ticks, draws a type and
// the next gap from the upstream random value, and offers the obstacle on a
// valid/ready channel while counting accepted obstacles.
module obstacle_spawner
  import obstacle_spawner_pkg::*;
#(
  parameter int MIN_GAP = 4,
  parameter int COUNT_W = 8
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               frame_tick_in,
  input  logic               game_active_in,
  input  logic [3:0]         rand_in,
  obstacle_spawner_if.master obs_if,
  output logic [COUNT_W-1:0] spawned_count_out
);

  localparam logic [GAP_W-1:0]   MIN_GAP_C = GAP_W'(MIN_GAP);
  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_e             state_r,   state_s;
  logic [GAP_W-1:0]   gap_cnt_r, gap_cnt_s;
  logic               valid_r,   valid_s;
  logic [1:0]         type_r,    type_s;
  logic [GAP_W-1:0]   gap_r,     gap_s;
  logic [COUNT_W-1:0] count_r,   count_s;
  logic [1:0]         dec_type_s;
  logic [GAP_W-1:0]   dec_gap_s;

  // State and output registers; reset overrides any same-cycle handshake.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r   <= ST_IDLE;
      gap_cnt_r <= {GAP_W{1'b0}};
      valid_r   <= 1'b0;
      type_r    <= 2'd0;
      gap_r     <= {GAP_W{1'b0}};
      count_r   <= {COUNT_W{1'b0}};
    end else begin
      state_r   <= state_s;
      gap_cnt_r <= gap_cnt_s;
      valid_r   <= valid_s;
      type_r    <= type_s;
      gap_r     <= gap_s;
      count_r   <= count_s;
    end
  end

  // Next-state and next-output logic; deactivation outranks every in-run event.
  always_comb begin
    state_s    = state_r;
    gap_cnt_s  = gap_cnt_r;
    valid_s    = valid_r;
    type_s     = type_r;
    gap_s      = gap_r;
    count_s    = count_r;
    dec_type_s = rand_in[1:0];
    dec_gap_s  = calc_gap(MIN_GAP_C, rand_in[3:2]);

    if ((state_r != ST_IDLE) && !game_active_in) begin
      state_s = ST_IDLE;
      valid_s = 1'b0;
      type_s  = 2'd0;
      gap_s   = {GAP_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          valid_s = 1'b0;
          type_s  = 2'd0;
          gap_s   = {GAP_W{1'b0}};
          if (game_active_in) begin
            gap_cnt_s = MIN_GAP_C;
            count_s   = {COUNT_W{1'b0}};
            state_s   = ST_WAIT_GAP;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_WAIT_GAP: begin
          if (frame_tick_in) begin
            gap_cnt_s = gap_cnt_r - {{(GAP_W-1){1'b0}}, 1'b1};
            if (gap_cnt_r == {{(GAP_W-1){1'b0}}, 1'b1}) begin
              state_s = ST_DECIDE;
            end else begin
              state_s = ST_WAIT_GAP;
            end
          end else begin
            state_s = ST_WAIT_GAP;
          end
        end
        ST_DECIDE: begin
          if (dec_type_s == OBS_NONE) begin
            gap_cnt_s = dec_gap_s;
            state_s   = ST_WAIT_GAP;
          end else begin
            type_s  = dec_type_s;
            gap_s   = dec_gap_s;
            valid_s = 1'b1;
            state_s = ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Ticks are ignored here; the next gap starts counting only after acceptance.
          if (valid_r && obs_if.obs_ready_in) begin
            valid_s   = 1'b0;
            gap_cnt_s = gap_r;
            state_s   = ST_WAIT_GAP;
            if (count_r != COUNT_MAX) begin
              count_s = count_r + COUNT_ONE;
            end else begin
              count_s = count_r;
            end
          end else begin
            state_s = ST_HOLD;
          end
        end
        default: begin
          state_s = ST_IDLE;
          valid_s = 1'b0;
          type_s  = 2'd0;
          gap_s   = {GAP_W{1'b0}};
        end
      endcase
    end
  end

  assign obs_if.obs_valid_out = valid_r;
  assign obs_if.obs_type_out  = type_r;
  assign obs_if.obs_gap_out   = gap_r;
  assign spawned_count_out    = count_r;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Self-checking bench for obstacle_spawner: directed scenarios plus random
// traffic, all compared against a frame-level reference model.
module tb_obstacle_spawner;
  import obstacle_spawner_pkg::*;

  localparam int MIN_GAP = 4;
  localparam int COUNT_W = 8;
  localparam int CNT_MAX = (1 << COUNT_W) - 1;

  logic               clk_in = 1'b0;
  logic               rst_in = 1'b0;
  logic               frame_tick_in = 1'b0;
  logic               game_active_in = 1'b0;
  logic [3:0]         rand_in = 4'd0;
  logic [COUNT_W-1:0] spawned_count_out;

  int checks = 0;
  int errors = 0;

  // Reference model: run flag, ticks left before a draw, pending offer.
  bit m_run = 1'b0;
  bit m_draw = 1'b0;
  bit m_offer = 1'b0;
  int m_left = 0;
  int m_type = 0;
  int m_gap = 0;
  int m_count = 0;

  obstacle_spawner_if obs_if ();

  obstacle_spawner #(.MIN_GAP(MIN_GAP), .COUNT_W(COUNT_W)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .frame_tick_in     (frame_tick_in),
    .game_active_in    (game_active_in),
    .rand_in           (rand_in),
    .obs_if            (obs_if),
    .spawned_count_out (spawned_count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    int t;
    int g;
    if (rst_in) begin
      m_run = 1'b0; m_draw = 1'b0; m_offer = 1'b0;
      m_left = 0; m_type = 0; m_gap = 0; m_count = 0;
    end else if (!m_run) begin
      if (game_active_in) begin
        m_run = 1'b1; m_left = MIN_GAP; m_count = 0;
      end
    end else if (!game_active_in) begin
      m_run = 1'b0; m_draw = 1'b0; m_offer = 1'b0; m_type = 0; m_gap = 0;
    end else if (m_draw) begin
      m_draw = 1'b0;
      t = int'(rand_in) % 4;
      g = MIN_GAP + int'(rand_in) / 4;
      if (t == 3) begin
        m_left = g;
      end else begin
        m_offer = 1'b1; m_type = t; m_gap = g;
      end
    end else if (m_offer) begin
      if (obs_if.obs_ready_in) begin
        m_offer = 1'b0;
        m_left = m_gap;
        if (m_count < CNT_MAX) m_count = m_count + 1;
      end
    end else if (frame_tick_in) begin
      m_left = m_left - 1;
      if (m_left == 0) m_draw = 1'b1;
    end
  endtask

  task automatic step(input logic rst, input logic act, input logic tick,
                      input logic [3:0] rnd, input logic rdy);
    rst_in = rst;
    game_active_in = act;
    frame_tick_in = tick;
    rand_in = rnd;
    obs_if.obs_ready_in = rdy;
    @(posedge clk_in);
    model_edge();
    #1;
    check_eq("valid", int'(obs_if.obs_valid_out), int'(m_offer));
    check_eq("type", int'(obs_if.obs_type_out), m_type);
    check_eq("gap", int'(obs_if.obs_gap_out), m_gap);
    check_eq("count", int'(spawned_count_out), m_count);
  endtask

  task automatic expect_out(input string tag, input int v, input int t,
                            input int g, input int c);
    check_eq({tag, "_valid"}, int'(obs_if.obs_valid_out), v);
    check_eq({tag, "_type"}, int'(obs_if.obs_type_out), t);
    check_eq({tag, "_gap"}, int'(obs_if.obs_gap_out), g);
    check_eq({tag, "_count"}, int'(spawned_count_out), c);
  endtask

  initial begin
    obs_if.obs_ready_in = 1'b0;

    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    expect_out("reset", 0, 0, 0, 0);

    // Start a run and reach the first decision after MIN_GAP ticks.
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    expect_out("start", 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b1, 4'b0101, 1'b0);
      check_eq("pre_decide_valid", int'(obs_if.obs_valid_out), 0);
    end
    step(1'b0, 1'b1, 1'b0, 4'b0101, 1'b0);
    expect_out("first_obs", 1, 1, 5, 0);

    // Consumer stalls while ticks keep arriving: offer must not move.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);
      expect_out("stall", 1, 1, 5, 0);
    end
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
    check_eq("accept_valid", int'(obs_if.obs_valid_out), 0);
    check_eq("accept_count", int'(spawned_count_out), 1);

    // Next decision exactly obs_gap (5) ticks after acceptance.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
      check_eq("gap5_wait_valid", int'(obs_if.obs_valid_out), 0);
    end
    step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    expect_out("second_obs", 1, 0, 4, 1);
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
    check_eq("second_accept_count", int'(spawned_count_out), 2);

    // Skip decision: nothing offered, the gap reloads to MIN_GAP.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'b0011, 1'b0);
    check_eq("skip_valid", int'(obs_if.obs_valid_out), 0);
    check_eq("skip_count", int'(spawned_count_out), 2);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
      check_eq("skip_wait_valid", int'(obs_if.obs_valid_out), 0);
    end
    step(1'b0, 1'b1, 1'b0, 4'b1010, 1'b0);
    expect_out("after_skip_obs", 1, 2, 6, 2);

    // Deactivate during HOLD, with ready and tick in the same cycle.
    step(1'b0, 1'b0, 1'b1, 4'd0, 1'b1);
    expect_out("deact", 0, 0, 0, 2);
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    expect_out("idle", 0, 0, 0, 2);

    // Reset colliding with an accepted handshake.
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 4'd1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'd1, 1'b0);
    expect_out("pre_rst_obs", 1, 1, 4, 0);
    step(1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
    expect_out("rst_vs_accept", 0, 0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

    // Saturation: ~333 acceptances with an always-ready consumer.
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 2000; i++) step(1'b0, 1'b1, 1'b1, 4'd0, 1'b1);
    check_eq("saturate", int'(spawned_count_out), CNT_MAX);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(255) == 0),
           ($urandom_range(63) != 0),
           logic'($urandom_range(1)),
           4'($urandom_range(15)),
           logic'($urandom_range(1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
